// File: rtl/sensor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : sensor_pkg                                                      |
// | Shared constants, scheduler state type and mod-5 helper.                 |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package sensor_pkg;
  localparam int SENSOR_W = 4;
  localparam int REST_W   = 3;
  localparam int MOD_DIV  = 5;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_t;

  function automatic logic [REST_W-1:0] mod5(input logic [SENSOR_W-1:0] v);
    return REST_W'(v % SENSOR_W'(MOD_DIV));
  endfunction
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rr_arbiter                                                      |
// | Round-robin priority search starting at ptr; one-hot and encoded grant.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic           en,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic           w_found;
  logic [IDW-1:0] w_idx;
  int             w_sum;

  // ptr is always < N, so a single conditional subtract implements mod N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = 0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = IDW'(w_sum);
      if (en && !w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sensor_mod5_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : sensor_mod5_scheduler                                           |
// | Round-robin shared mod-5 unit with tagged registered result and counter. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module sensor_mod5_scheduler
  import sensor_pkg::*;
#(
  parameter int N_SENSORS = 4,
  parameter int ID_W      = 2,
  parameter int CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [N_SENSORS-1:0]          req_valid,
  input  logic [SENSOR_W*N_SENSORS-1:0] req_data,
  output logic [N_SENSORS-1:0]          req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [REST_W-1:0]             out_rest,
  output logic [ID_W-1:0]               out_id,
  output logic [CNT_W-1:0]              zero_cnt,
  input  logic                          clr_cnt
);

  localparam logic [ID_W-1:0]  c_last_id = ID_W'(N_SENSORS - 1);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  sched_state_t          r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [REST_W-1:0]     r_rest;
  logic [ID_W-1:0]       r_id;
  logic [CNT_W-1:0]      r_zero_cnt;

  logic                  w_slot_free;
  logic                  w_grant_en;
  logic                  w_any;
  logic [N_SENSORS-1:0]  w_gnt;
  logic [ID_W-1:0]       w_gnt_idx;
  logic [SENSOR_W-1:0]   w_sel_data;
  logic [REST_W-1:0]     w_rest;
  logic [ID_W-1:0]       w_next_ptr;

  // rst_n gates the handshake so no request is accepted while reset is held.
  assign w_slot_free = (r_state == EMPTY) || out_ready;
  assign w_grant_en  = en && w_slot_free && rst_n;
  assign w_any       = |w_gnt;

  rr_arbiter #(
    .N   (N_SENSORS),
    .IDW (ID_W)
  ) u_arb (
    .req     (req_valid),
    .en      (w_grant_en),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (w_gnt[i]) w_sel_data = req_data[SENSOR_W*i +: SENSOR_W];
    end
  end

  assign w_rest     = mod5(w_sel_data);
  assign w_next_ptr = (w_gnt_idx == c_last_id) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_ptr      <= '0;
      r_rest     <= '0;
      r_id       <= '0;
      r_zero_cnt <= '0;
    end else begin
      if (w_any) begin
        r_state <= FULL;
        r_rest  <= w_rest;
        r_id    <= w_gnt_idx;
        r_ptr   <= w_next_ptr;
      end else if ((r_state == FULL) && out_ready) begin
        r_state <= EMPTY;
      end

      if (clr_cnt) begin
        r_zero_cnt <= '0;
      end else if (w_any && (w_rest == '0) && (r_zero_cnt != c_cnt_max)) begin
        r_zero_cnt <= r_zero_cnt + 1'b1;
      end
    end
  end

  assign req_ready = w_gnt;
  assign out_valid = (r_state == FULL);
  assign out_rest  = r_rest;
  assign out_id    = r_id;
  assign zero_cnt  = r_zero_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sensor_mod5_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_sensor_mod5_scheduler                                        |
// | Scenario tasks plus randomized run against a behavioural model.          |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sensor_mod5_scheduler;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n, en, out_ready, clr_cnt;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [2:0]  out_rest;
  logic [1:0]  out_id;
  logic [7:0]  zero_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_ptr, m_rest, m_id, m_zc;
  bit m_pending;

  always #5 clk = ~clk;

  sensor_mod5_scheduler #(.N_SENSORS(4), .ID_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_rest(out_rest), .out_id(out_id), .zero_cnt(zero_cnt), .clr_cnt(clr_cnt)
  );

  function automatic int model_grant();
    if (!rst_n || !en || (m_pending && !out_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int g;
    g = model_grant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_rest = 0; m_id = 0; m_zc = 0; m_pending = 0;
  endfunction

  // one clock: model decision taken on stable pre-edge inputs, returns at negedge
  task automatic tick();
    int g, r;
    g = model_grant();
    r = (g < 0) ? -1 : ((int'(req_data) >> (4 * g)) & 15) % 5;
    @(posedge clk);
    if (clr_cnt) m_zc = 0;
    else if (g >= 0 && r == 0 && m_zc < 255) m_zc++;
    if (g >= 0) begin
      m_pending = 1; m_rest = r; m_id = g; m_ptr = (g + 1) % N;
    end else if (m_pending && out_ready) begin
      m_pending = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b0; clr_cnt = 1'b0;
    req_valid = '0; req_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0d expected 0", out_valid); end
    n_cmp++; if (out_rest !== 3'd0) begin n_err++; $display("FAIL reset_rest: got %0d expected 0", out_rest); end
    n_cmp++; if (out_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d expected 0", out_id); end
    n_cmp++; if (zero_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", zero_cnt); end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001; req_data = 16'd13;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0d expected 1", out_valid); end
    n_cmp++; if (out_rest !== 3'd3) begin n_err++; $display("FAIL single_rest: got %0d expected 3", out_rest); end
    n_cmp++; if (out_id !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d expected 0", out_id); end
  endtask

  task automatic test_all_four();
    int ids[5]   = '{0, 1, 2, 3, 0};
    int rests[5] = '{0, 1, 4, 0, 0};
    do_reset();
    out_ready = 1'b1; req_valid = 4'b1111;
    req_data = {4'd15, 4'd9, 4'd6, 4'd5};
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (req_ready !== 4'(1 << ids[i])) begin n_err++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, req_ready, 4'(1 << ids[i])); end
      tick();
      n_cmp++; if (out_id !== 2'(ids[i]) || out_rest !== 3'(rests[i]) || out_valid !== 1'b1) begin
        n_err++; $display("FAIL rr_out[%0d]: got id=%0d rest=%0d v=%0d expected id=%0d rest=%0d v=1", i, out_id, out_rest, out_valid, ids[i], rests[i]);
      end
      if (i == 3) begin
        n_cmp++; if (zero_cnt !== 8'd2) begin n_err++; $display("FAIL rr_zero_cnt: got %0d expected 2", zero_cnt); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req_valid = 4'b0100; req_data = {4'd8, 4'd7, 4'd0, 4'd0};
    tick();
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b expected 0000", i, req_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_rest !== 3'd2 || out_id !== 2'd2) begin
        n_err++; $display("FAIL stall_hold[%0d]: got v=%0d rest=%0d id=%0d expected v=1 rest=2 id=2", i, out_valid, out_rest, out_id);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL b2b_ready: got %b expected 1000", req_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'd3 || out_rest !== 3'd3) begin
      n_err++; $display("FAIL b2b_out: got v=%0d id=%0d rest=%0d expected v=1 id=3 rest=3", out_valid, out_id, out_rest);
    end
  endtask

  task automatic test_wrap_en();
    do_reset();
    out_ready = 1'b1; req_valid = 4'b0100; req_data = 16'h1234;
    tick();
    req_valid = 4'b1001;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_ready3: got %b expected 1000", req_ready); end
    tick();
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_ready0: got %b expected 0001", req_ready); end
    tick();
    n_cmp++; if (out_id !== 2'd0 || out_valid !== 1'b1) begin n_err++; $display("FAIL wrap_id: got %0d expected 0", out_id); end
    en = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL en_block: got %b expected 0000", req_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL en_drain: got %0d expected 0", out_valid); end
  endtask

  task automatic test_counter();
    do_reset();
    out_ready = 1'b1; req_valid = 4'b0001; req_data = 16'd10;
    repeat (260) tick();
    n_cmp++; if (zero_cnt !== 8'd255 || m_zc != 255) begin n_err++; $display("FAIL cnt_sat: got %0d expected 255", zero_cnt); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    n_cmp++; if (zero_cnt !== 8'd0) begin n_err++; $display("FAIL cnt_clr: got %0d expected 0", zero_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_data  = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      clr_cnt   = ($urandom_range(0, 31) == 0);
      #1;
      n_cmp++; if (req_ready !== model_ready()) begin n_err++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, req_ready, model_ready()); end
      tick();
      n_cmp++;
      if (out_valid !== m_pending || zero_cnt !== 8'(m_zc) ||
          (m_pending && (out_rest !== 3'(m_rest) || out_id !== 2'(m_id)))) begin
        n_err++; $display("FAIL rand_out[%0d]: got v=%0d rest=%0d id=%0d cnt=%0d expected v=%0d rest=%0d id=%0d cnt=%0d",
                          i, out_valid, out_rest, out_id, zero_cnt, m_pending, m_rest, m_id, m_zc);
      end
    end
    clr_cnt = 1'b0; en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b1111; req_data = 16'h2222;
    tick();
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %0d expected 0", out_valid); end
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL areset_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL areset_first: got %b expected 0001", req_ready); end
    tick();
    n_cmp++; if (out_id !== 2'd0 || out_valid !== 1'b1) begin n_err++; $display("FAIL areset_id: got %0d expected 0", out_id); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    req_valid = '0; req_data = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_four();
    test_stall();
    test_wrap_en();
    test_counter();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
